// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 icode/stat constants and pipeline control FSM states
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] S_AOK = 4'h1;
  localparam logic [3:0] S_HLT = 4'h2;
  localparam logic [3:0] S_ADR = 4'h3;
  localparam logic [3:0] S_INS = 4'h4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - Y86-64 pipeline stall/bubble control, reset flush, halt latch and perf counters
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int INIT_CYCLES = 5,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [3:0]       final_stat,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bub_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  init_cnt_q, init_cnt_d;
  logic           halted_q, halted_d;
  logic [3:0]     final_stat_q, final_stat_d;

  logic lu, mis, ret, exc_m, exc_w, run;

  assign lu    = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != RNONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mis   = (E_icode == I_JXX) && !e_Cnd;
  assign ret   = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign exc_m = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
  assign exc_w = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);
  assign run   = (state_q == ST_RUN);

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    halted_d     = halted_q;
    final_stat_d = final_stat_q;
    F_stall      = 1'b0;
    D_stall      = 1'b0;
    D_bubble     = 1'b0;
    E_bubble     = 1'b0;
    M_bubble     = 1'b0;
    W_stall      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        if (init_cnt_q == '0) state_d = ST_RUN;
        else                  init_cnt_d = init_cnt_q - IW'(1);
      end
      ST_RUN: begin
        F_stall  = lu | ret;
        D_stall  = lu;
        D_bubble = mis | (!lu & ret);
        E_bubble = mis | lu;
        M_bubble = exc_m | exc_w;
        W_stall  = exc_w;
        if (exc_w) begin
          state_d      = ST_HALT;
          halted_d     = 1'b1;
          final_stat_d = W_stat;
        end
      end
      ST_HALT: begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        W_stall  = 1'b1;
        M_bubble = 1'b1;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= IW'(INIT_CYCLES - 1);
      halted_q     <= 1'b0;
      final_stat_q <= S_AOK;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      halted_q     <= halted_d;
      final_stat_q <= final_stat_d;
    end
  end

  assign halted     = halted_q;
  assign final_stat = final_stat_q;

  // Counters only advance in RUN; INIT and HALT leave them frozen.
  sat_counter #(.W(CNT_W)) u_cyc_cnt (
    .clk(clk), .rst_n(rst_n), .inc(run), .cnt(cyc_cnt));
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .inc(run & F_stall), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_bub_cnt (
    .clk(clk), .rst_n(rst_n), .inc(run & (D_bubble | E_bubble)), .cnt(bub_cnt));
  sat_counter #(.W(CNT_W)) u_ret_cnt (
    .clk(clk), .rst_n(rst_n), .inc(run & (W_stat == S_AOK) & (W_icode != I_NOP)), .cnt(ret_cnt));

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl against a behavioural model
module tb_pipe_ctrl;

  localparam int INIT = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, m_stat, W_icode, W_stat;
  logic       e_Cnd;

  logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [3:0]  final_stat;
  logic [31:0] cyc_cnt, stall_cnt, bub_cnt, ret_cnt;

  logic        F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4, halted4;
  logic [3:0]  final_stat4;
  logic [3:0]  cyc_cnt4, stall_cnt4, bub_cnt4, ret_cnt4;

  logic [5:0] ctl, ctl4;
  assign ctl  = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};
  assign ctl4 = {F_stall4, D_stall4, D_bubble4, E_bubble4, M_bubble4, W_stall4};

  pipe_ctrl #(.INIT_CYCLES(INIT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
    .W_icode(W_icode), .W_stat(W_stat), .F_stall(F_stall), .D_stall(D_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .final_stat(final_stat), .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt),
    .bub_cnt(bub_cnt), .ret_cnt(ret_cnt));

  pipe_ctrl #(.INIT_CYCLES(INIT), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd), .M_icode(M_icode), .m_stat(m_stat),
    .W_icode(W_icode), .W_stat(W_stat), .F_stall(F_stall4), .D_stall(D_stall4),
    .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4), .W_stall(W_stall4),
    .halted(halted4), .final_stat(final_stat4), .cyc_cnt(cyc_cnt4), .stall_cnt(stall_cnt4),
    .bub_cnt(bub_cnt4), .ret_cnt(ret_cnt4));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: cycles since reset release decide INIT vs RUN, a halt flag decides HALT.
  int              rc = 0;
  bit              m_halt = 1'b0;
  logic [3:0]      m_fs = 4'h1;
  longint unsigned m_cyc = 0, m_stl = 0, m_bub = 0, m_ret = 0;

  function automatic bit is_exc(input logic [3:0] s);
    return (s == 4'h2) || (s == 4'h3) || (s == 4'h4);
  endfunction

  function automatic logic [5:0] rule_ctl();
    bit lu, mis, ret, xm, xw;
    lu  = ((E_icode == 4'h5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
          ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    mis = (E_icode == 4'h7) && !e_Cnd;
    ret = (D_icode == 4'h9) || (E_icode == 4'h9) || (M_icode == 4'h9);
    xm  = is_exc(m_stat);
    xw  = is_exc(W_stat);
    return {lu | ret, lu, mis | (!lu && ret), mis | lu, xm | xw, xw};
  endfunction

  function automatic logic [5:0] exp_ctl();
    if (m_halt)    return 6'b110011;
    if (rc < INIT) return 6'b101110;
    return rule_ctl();
  endfunction

  function automatic logic [3:0] sat4(input longint unsigned v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [5:0] c;
    if (!rst_n) begin
      rc = 0; m_halt = 1'b0; m_fs = 4'h1;
      m_cyc = 0; m_stl = 0; m_bub = 0; m_ret = 0;
    end else begin
      if (!m_halt && rc >= INIT) begin
        c = rule_ctl();
        m_cyc++;
        if (c[5]) m_stl++;
        if (c[3] | c[2]) m_bub++;
        if (W_stat == 4'h1 && W_icode != 4'h1) m_ret++;
        if (is_exc(W_stat)) begin
          m_halt = 1'b1;
          m_fs   = W_stat;
        end
      end
      if (rc < 1000000) rc++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl", ctl, exp_ctl());
      chk("halted", halted, m_halt);
      chk("final_stat", final_stat, m_fs);
      chk("cyc_cnt", cyc_cnt, m_cyc[31:0]);
      chk("stall_cnt", stall_cnt, m_stl[31:0]);
      chk("bub_cnt", bub_cnt, m_bub[31:0]);
      chk("ret_cnt", ret_cnt, m_ret[31:0]);
      chk("ctl4", ctl4, exp_ctl());
      chk("cyc_cnt4", cyc_cnt4, sat4(m_cyc));
      chk("stall_cnt4", stall_cnt4, sat4(m_stl));
      chk("bub_cnt4", bub_cnt4, sat4(m_bub));
      chk("ret_cnt4", ret_cnt4, sat4(m_ret));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF; e_Cnd = 1'b0;
    m_stat = 4'h1; W_stat = 4'h1;
  endtask

  task automatic apply(input string nm, input logic [3:0] di, input logic [3:0] ei,
                       input logic [3:0] dm, input logic [3:0] sa, input logic [3:0] sb,
                       input logic c, input logic [3:0] mi, input logic [3:0] ms,
                       input logic [3:0] wi, input logic [3:0] ws, input logic [5:0] ec);
    D_icode = di; E_icode = ei; E_dstM = dm; d_srcA = sa; d_srcB = sb; e_Cnd = c;
    M_icode = mi; m_stat = ms; W_icode = wi; W_stat = ws;
    #1 chk(nm, ctl, ec);
    step();
  endtask

  task automatic flush_then_run(input string nm);
    for (int i = 0; i < INIT; i++) begin
      #1 chk({nm, "_flush"}, ctl, 6'b101110);
      step();
    end
    #1 chk({nm, "_run"}, ctl, 6'b000000);
  endtask

  initial begin
    idle();
    chk_en = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ctl", ctl, 6'b101110);
    chk("rst_halted", halted, 1'b0);
    chk("rst_final_stat", final_stat, 4'h1);
    chk("rst_cyc", cyc_cnt, 32'd0);
    step();
    rst_n = 1'b1;
    flush_then_run("boot");
    chk("boot_cyc0", cyc_cnt, 32'd0);
    step();
    chk("boot_cyc1", cyc_cnt, 32'd1);

    apply("ld_use",    4'h1, 4'h5, 4'h3, 4'h3, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 6'b110100);
    chk("ld_use_stall_cnt", stall_cnt, 32'd1);
    apply("ld_none",   4'h1, 4'h5, 4'hF, 4'h3, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 6'b000000);
    apply("mis",       4'h1, 4'h7, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 6'b001100);
    apply("mis_taken", 4'h1, 4'h7, 4'hF, 4'hF, 4'hF, 1'b1, 4'h1, 4'h1, 4'h6, 4'h1, 6'b000000);
    apply("ret_d",     4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 6'b101000);
    apply("ret_e",     4'h1, 4'h9, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 6'b101000);
    apply("ret_m",     4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h9, 4'h1, 4'h1, 4'h1, 6'b101000);
    apply("lu_ret",    4'h9, 4'h5, 4'h3, 4'h3, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 6'b110100);
    apply("mis_ret",   4'h9, 4'h7, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 6'b101100);
    apply("ld_srcB",   4'h1, 4'hB, 4'h4, 4'hF, 4'h4, 1'b0, 4'h1, 4'h1, 4'h1, 4'h1, 6'b110100);
    apply("exc_m",     4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h3, 4'h1, 4'h1, 6'b000010);
    apply("exc_m_lu",  4'h1, 4'h5, 4'h3, 4'h3, 4'hF, 1'b0, 4'h1, 4'h4, 4'h1, 4'h1, 6'b110110);
    apply("exc_w",     4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 4'h1, 4'h1, 4'h1, 4'h3, 6'b000011);

    idle();
    #1;
    chk("halt_halted", halted, 1'b1);
    chk("halt_final_stat", final_stat, 4'h3);
    chk("halt_ctl", ctl, 6'b110011);
    chk("halt_cyc", cyc_cnt, 32'd14);
    chk("halt_stall", stall_cnt, 32'd8);
    chk("halt_bub", bub_cnt, 32'd9);
    chk("halt_ret", ret_cnt, 32'd1);
    repeat (10) step();
    chk("frozen_cyc", cyc_cnt, 32'd14);
    chk("frozen_stall", stall_cnt, 32'd8);

    rst_n = 1'b0;
    #1;
    chk("rst_halt_halted", halted, 1'b0);
    chk("rst_halt_cyc", cyc_cnt, 32'd0);
    chk("rst_halt_ctl", ctl, 6'b101110);
    step();
    rst_n = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    #1 chk("rst_init_ctl", ctl, 6'b101110);
    step();
    rst_n = 1'b1;
    flush_then_run("replay");
    repeat (20) step();
    chk("run20_cyc", cyc_cnt, 32'd20);
    chk("run20_cyc4_sat", cyc_cnt4, 4'hF);

    for (int seg = 0; seg < 4; seg++) begin
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int n = 0; n < 200; n++) begin
        int r;
        D_icode = 4'($urandom_range(0, 11));
        E_icode = 4'($urandom_range(0, 11));
        M_icode = 4'($urandom_range(0, 11));
        W_icode = 4'($urandom_range(0, 11));
        d_srcA  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        d_srcB  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        E_dstM  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 3));
        e_Cnd   = 1'($urandom_range(0, 1));
        r = int'($urandom_range(0, 19));
        m_stat  = (r < 3) ? 4'($urandom_range(0, 4)) : 4'h1;
        r = int'($urandom_range(0, 199));
        W_stat  = (r < 2) ? 4'($urandom_range(2, 4)) : ((r < 12) ? 4'h0 : 4'h1);
        if (seg == 2 && n == 77) begin
          #2 rst_n = 1'b0;
          #1 rst_n = 1'b1;
        end
        step();
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
